// File: rtl/lcd_refresh_sched.sv
// rtl/lcd_refresh_sched.sv - HD44780 init and two-line refresh sequencer for timer/latched digits
// Optional leading-zero blanking of the frame snapshot: define LCD_LEAD_BLANK_EN.
module lcd_refresh_sched #(
    parameter int E_PULSE     = 12,
    parameter int CMD_WAIT    = 2000,
    parameter int CLR_WAIT    = 82000,
    parameter int PWR_WAIT    = 750000,
    parameter int REFRESH_GAP = 500000,
    parameter int WAIT_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] t_lcd,
    input  logic [35:0] latch_lcd,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        init_done,
    output logic        frame_done
);
    typedef enum logic [1:0] {ST_PWR, ST_INIT, ST_FRAME, ST_GAP} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_WAIT} phase_t;

    localparam logic [WAIT_W-1:0] E_LAST   = WAIT_W'(E_PULSE - 1);
    localparam logic [WAIT_W-1:0] CMD_LAST = WAIT_W'((CMD_WAIT > 0) ? CMD_WAIT - 1 : 0);
    localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'((CLR_WAIT > 0) ? CLR_WAIT - 1 : 0);
    localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'((PWR_WAIT > 0) ? PWR_WAIT - 1 : 0);
    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'((REFRESH_GAP > 0) ? REFRESH_GAP - 1 : 0);
    localparam bit CMD_ZERO = (CMD_WAIT == 0);
    localparam bit CLR_ZERO = (CLR_WAIT == 0);
    localparam bit PWR_ZERO = (PWR_WAIT == 0);
    localparam bit GAP_ZERO = (REFRESH_GAP == 0);

    state_t            r_state, w_state_nx;
    phase_t            r_phase, w_phase_nx;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0]        r_idx, w_idx_nx;
    logic [35:0]       r_snap_t, r_snap_l;
    logic [35:0]       w_snap_t, w_snap_l;
    logic              r_lcd_rs, r_lcd_e, r_init_done, r_frame_done;
    logic [7:0]        r_lcd_data;
    logic              w_load, w_fd, w_end, w_last, w_wait_zero, w_bus_nx;
    logic [WAIT_W-1:0] w_wait_last;
    logic [8:0]        w_code;

`ifdef LCD_LEAD_BLANK_EN
    // Blank '0' codes from the MSD down until the first non-'0'; the LSD always shows.
    function automatic logic [35:0] f_blank(input logic [35:0] c);
        logic [35:0] r;
        logic        lead;
        r    = c;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && c[i*9 +: 9] == 9'h130) r[i*9 +: 9] = 9'h120;
            else                               lead = 1'b0;
        end
        return r;
    endfunction
    assign w_snap_t = f_blank(t_lcd);
    assign w_snap_l = f_blank(latch_lcd);
`else
    assign w_snap_t = t_lcd;
    assign w_snap_l = latch_lcd;
`endif

    always_comb begin
        w_wait_last = CMD_LAST;
        w_wait_zero = CMD_ZERO;
        if (r_state == ST_INIT && r_idx == 4'd2) begin
            w_wait_last = CLR_LAST;
            w_wait_zero = CLR_ZERO;
        end
        w_last = (r_state == ST_INIT) ? (r_idx == 4'd3) : (r_idx == 4'd9);
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt + WAIT_W'(1);
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        w_fd       = 1'b0;
        w_end      = 1'b0;
        case (r_state)
            ST_PWR: begin
                if (PWR_ZERO || r_cnt == PWR_LAST) begin
                    w_state_nx = ST_INIT;
                    w_phase_nx = PH_SETUP;
                    w_idx_nx   = 4'd0;
                    w_cnt_nx   = '0;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nx = ST_FRAME;
                    w_phase_nx = PH_SETUP;
                    w_idx_nx   = 4'd0;
                    w_cnt_nx   = '0;
                    w_load     = 1'b1;
                end
            end
            default: begin
                case (r_phase)
                    PH_SETUP: begin
                        w_phase_nx = PH_EHI;
                        w_cnt_nx   = '0;
                    end
                    PH_EHI: begin
                        if (r_cnt == E_LAST) begin
                            if (w_wait_zero) begin
                                w_end = 1'b1;
                            end else begin
                                w_phase_nx = PH_WAIT;
                                w_cnt_nx   = '0;
                            end
                        end
                    end
                    default: if (r_cnt == w_wait_last) w_end = 1'b1;
                endcase
            end
        endcase
        // End of a write: advance the index, or hand over to the next frame/gap.
        if (w_end) begin
            w_cnt_nx   = '0;
            w_phase_nx = PH_SETUP;
            if (!w_last) begin
                w_idx_nx = r_idx + 4'd1;
            end else begin
                w_idx_nx = 4'd0;
                if (r_state == ST_FRAME) begin
                    w_fd = 1'b1;
                    if (GAP_ZERO) w_load = 1'b1;
                    else          w_state_nx = ST_GAP;
                end else begin
                    w_state_nx = ST_FRAME;
                    w_load     = 1'b1;
                end
            end
        end
    end

    assign w_bus_nx = (w_state_nx == ST_INIT) || (w_state_nx == ST_FRAME);

    always_comb begin
        w_code = 9'h000;
        if (w_state_nx == ST_INIT) begin
            case (w_idx_nx)
                4'd0:    w_code = 9'h038;
                4'd1:    w_code = 9'h00C;
                4'd2:    w_code = 9'h001;
                default: w_code = 9'h006;
            endcase
        end else if (w_state_nx == ST_FRAME) begin
            case (w_idx_nx)
                4'd1:    w_code = r_snap_t[35:27];
                4'd2:    w_code = r_snap_t[26:18];
                4'd3:    w_code = r_snap_t[17:9];
                4'd4:    w_code = r_snap_t[8:0];
                4'd5:    w_code = 9'h0C0;
                4'd6:    w_code = r_snap_l[35:27];
                4'd7:    w_code = r_snap_l[26:18];
                4'd8:    w_code = r_snap_l[17:9];
                4'd9:    w_code = r_snap_l[8:0];
                default: w_code = 9'h080;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_PWR;
            r_phase      <= PH_SETUP;
            r_cnt        <= '0;
            r_idx        <= 4'd0;
            r_snap_t     <= '0;
            r_snap_l     <= '0;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= 8'h00;
            r_lcd_e      <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_phase      <= w_phase_nx;
            r_cnt        <= w_cnt_nx;
            r_idx        <= w_idx_nx;
            r_lcd_e      <= w_bus_nx && (w_phase_nx == PH_EHI);
            r_init_done  <= r_init_done || (w_state_nx == ST_FRAME);
            r_frame_done <= w_fd;
            if (w_load) begin
                r_snap_t <= w_snap_t;
                r_snap_l <= w_snap_l;
            end
            // Bus only changes at SETUP, so RS/data stay put through E and the wait.
            if (w_bus_nx && w_phase_nx == PH_SETUP) begin
                r_lcd_rs   <= w_code[8];
                r_lcd_data <= w_code[7:0];
            end
        end
    end

    assign lcd_rs     = r_lcd_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = r_lcd_e;
    assign lcd_data   = r_lcd_data;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_lcd_refresh_sched.sv
// tb/tb_lcd_refresh_sched.sv - directed self-checking bench for lcd_refresh_sched
module tb_lcd_refresh_sched;
    logic        clk, rst;
    logic [35:0] t_lcd, latch_lcd;
    logic        lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0]  lcd_data;

    int nvec, nfail, cyc, rel, last_init, last_l0, fd_count, fd_seen, fd_cyc, init_cyc;
    logic       prev_e, cur_e, init_prev;
    logic [8:0] prev_code, cur_code;
    logic [8:0] exp_q [10];

    lcd_refresh_sched #(
        .E_PULSE(2), .CMD_WAIT(3), .CLR_WAIT(6), .PWR_WAIT(10), .REFRESH_GAP(4), .WAIT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .t_lcd(t_lcd), .latch_lcd(latch_lcd),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        prev_e    = cur_e;
        cur_e     = lcd_e;
        prev_code = cur_code;
        cur_code  = {lcd_rs, lcd_data};
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (init_done && !init_prev) init_cyc = cyc;
        init_prev = init_done;
    endtask

    task automatic capture_write(input bit full, output logic [8:0] code, output int rc, output bit ok);
        ok = 1'b0; code = '0; rc = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            tick();
            if (cur_e && !prev_e) ok = 1'b1;
        end
        if (!ok) begin
            nvec++; nfail++;
            $display("FAIL write_timeout: no lcd_e rise within 100 cycles at cycle %0d", cyc);
            return;
        end
        code = cur_code;
        rc   = cyc;
        nvec++;
        if (prev_code !== cur_code) begin
            nfail++;
            $display("FAIL setup_stable: setup code %h, at rise %h", prev_code, cur_code);
        end
        if (full) begin
            tick();
            nvec++;
            if (cur_e !== 1'b1 || cur_code !== code) begin
                nfail++;
                $display("FAIL e_high2: e=%b code=%h, required e=1 code=%h", cur_e, cur_code, code);
            end
            tick();
            nvec++;
            if (cur_e !== 1'b0 || cur_code !== code) begin
                nfail++;
                $display("FAIL e_fall: e=%b code=%h, required e=0 code=%h", cur_e, cur_code, code);
            end
        end
    endtask

    task automatic check_frame(input string name, input bit after, input int chg_k, input logic [35:0] chg_t);
        logic [8:0] code;
        int         rc, prev;
        bit         ok;
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            capture_write(1'b1, code, rc, ok);
            if (!ok) return;
            nvec++;
            if (code !== exp_q[k]) begin
                nfail++;
                $display("FAIL %s_code[%0d]: got %h, required %h", name, k, code, exp_q[k]);
            end
            if (k == 0 && after) begin
                nvec++;
                if (rc - last_l0 !== 10) begin
                    nfail++;
                    $display("FAIL %s_gap: L0->0x80 rise %0d cycles, required 10", name, rc - last_l0);
                end
                nvec++;
                if (fd_count !== fd_seen + 1 || fd_cyc - last_l0 !== 5) begin
                    nfail++;
                    $display("FAIL %s_frame_done: pulses %0d at +%0d, required 1 at +5",
                             name, fd_count - fd_seen, fd_cyc - last_l0);
                end
            end else if (k == 0) begin
                nvec++;
                if (rc - last_init !== 6) begin
                    nfail++;
                    $display("FAIL %s_first: 0x06->0x80 rise %0d cycles, required 6", name, rc - last_init);
                end
                nvec++;
                if (init_cyc !== last_init + 5) begin
                    nfail++;
                    $display("FAIL %s_init_done: rose at +%0d, required +5", name, init_cyc - last_init);
                end
            end else begin
                nvec++;
                if (rc - prev !== 6) begin
                    nfail++;
                    $display("FAIL %s_spacing[%0d]: %0d cycles, required 6", name, k, rc - prev);
                end
            end
            if (k == chg_k) t_lcd = chg_t;
            prev = rc;
        end
        last_l0 = prev;
        fd_seen = fd_count;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        nvec++; if (lcd_e !== 1'b0)      begin nfail++; $display("FAIL rst_e: got %b, required 0", lcd_e); end
        nvec++; if (lcd_rs !== 1'b0)     begin nfail++; $display("FAIL rst_rs: got %b, required 0", lcd_rs); end
        nvec++; if (lcd_data !== 8'h00)  begin nfail++; $display("FAIL rst_data: got %h, required 00", lcd_data); end
        nvec++; if (lcd_rw !== 1'b0)     begin nfail++; $display("FAIL rst_rw: got %b, required 0", lcd_rw); end
        nvec++; if (init_done !== 1'b0)  begin nfail++; $display("FAIL rst_init_done: got %b, required 0", init_done); end
        nvec++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic test_init(input string name);
        logic [8:0] ex [4];
        int         dt [4];
        logic [8:0] code;
        int         rc;
        bit         ok;
        ex = '{9'h038, 9'h00C, 9'h001, 9'h006};
        dt = '{11, 17, 23, 32};
        for (int k = 0; k < 4; k++) begin
            capture_write(1'b1, code, rc, ok);
            if (!ok) return;
            nvec++;
            if (code !== ex[k]) begin
                nfail++;
                $display("FAIL %s_code[%0d]: got %h, required %h", name, k, code, ex[k]);
            end
            nvec++;
            if (rc - rel !== dt[k]) begin
                nfail++;
                $display("FAIL %s_time[%0d]: rise at +%0d, required +%0d", name, k, rc - rel, dt[k]);
            end
            last_init = rc;
        end
        nvec++;
        if (init_done !== 1'b0) begin
            nfail++;
            $display("FAIL %s_init_early: init_done=%b during last init wait, required 0", name, init_done);
        end
    endtask

    task automatic test_frame();
        exp_q = '{9'h080, 9'h131, 9'h132, 9'h133, 9'h134, 9'h0C0, 9'h135, 9'h136, 9'h137, 9'h138};
        check_frame("frame1", 1'b0, -1, '0);
    endtask

    task automatic test_hold();
        exp_q = '{9'h080, 9'h131, 9'h132, 9'h133, 9'h134, 9'h0C0, 9'h135, 9'h136, 9'h137, 9'h138};
        check_frame("frame2", 1'b1, 3, {4{9'h139}});
        exp_q = '{9'h080, 9'h139, 9'h139, 9'h139, 9'h139, 9'h0C0, 9'h135, 9'h136, 9'h137, 9'h138};
        check_frame("frame3", 1'b1, -1, '0);
    endtask

    task automatic test_reset_mid();
        logic [8:0] code;
        int         rc;
        bit         ok;
        t_lcd     = {9'h130, 9'h130, 9'h135, 9'h130};
        latch_lcd = {4{9'h130}};
        capture_write(1'b0, code, rc, ok);
        if (!ok) return;
        nvec++;
        if (code !== 9'h080 || lcd_e !== 1'b1) begin
            nfail++;
            $display("FAIL mid_pre: code %h e=%b, required 080 e=1", code, lcd_e);
        end
        rst = 1'b1;
        tick();
        nvec++; if (lcd_e !== 1'b0)      begin nfail++; $display("FAIL mid_rst_e: got %b, required 0", lcd_e); end
        nvec++; if (init_done !== 1'b0)  begin nfail++; $display("FAIL mid_rst_init_done: got %b, required 0", init_done); end
        nvec++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL mid_rst_frame_done: got %b, required 0", frame_done); end
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic test_blank();
`ifdef LCD_LEAD_BLANK_EN
        exp_q = '{9'h080, 9'h120, 9'h120, 9'h135, 9'h130, 9'h0C0, 9'h120, 9'h120, 9'h120, 9'h130};
`else
        exp_q = '{9'h080, 9'h130, 9'h130, 9'h135, 9'h130, 9'h0C0, 9'h130, 9'h130, 9'h130, 9'h130};
`endif
        check_frame("blank", 1'b0, -1, '0);
    endtask

    initial begin
        nvec = 0; nfail = 0; cyc = 0; rel = 0; last_init = 0; last_l0 = 0;
        fd_count = 0; fd_seen = 0; fd_cyc = 0; init_cyc = 0;
        prev_e = 1'b0; cur_e = 1'b0; init_prev = 1'b0;
        prev_code = '0; cur_code = '0;
        rst       = 1'b1;
        t_lcd     = {9'h131, 9'h132, 9'h133, 9'h134};
        latch_lcd = {9'h135, 9'h136, 9'h137, 9'h138};
        test_reset();
        test_init("init");
        test_frame();
        test_hold();
        test_reset_mid();
        test_init("reinit");
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
